// File: rtl/serv_rf_ram_bridge_pkg.sv
// Shared definitions for the serial register-file RAM bridge.
//   REG_IDX_W : width of a register index (x0..x31 plus CSR registers)
//   CSR_BASE  : first index above the integer registers
//   RF_LAT    : cycles from request acceptance to the o_ready pulse
//   PASS_LEN  : bits streamed per register access
package serv_rf_ram_bridge_pkg;

    localparam int REG_IDX_W = 6;
    localparam int CSR_BASE  = 32;
    localparam int RF_LAT    = 2;
    localparam int PASS_LEN  = 32;
    localparam int CNT_W     = 6;

    // Pass-counter values (pcnt = 0 in the first cycle after acceptance).
    // Serial bits occupy pcnt RF_LAT .. RF_LAT+PASS_LEN-1; the last port 1
    // word write lands two cycles after the final bit.
    localparam logic [CNT_W-1:0] PCNT_STREAM_END = CNT_W'(PASS_LEN + RF_LAT - 1);
    localparam logic [CNT_W-1:0] PCNT_DRAIN_END  = CNT_W'(PASS_LEN + RF_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } rf_state_e;

endpackage

// File: rtl/serv_rf_shreg.sv
// WIDTH-bit parallel-load / serial-out register (LSB first).
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : load data_i this cycle, otherwise shift right by one
//   data_i        : parallel load value
//   bit_o         : current serial bit (register LSB)
module serv_rf_shreg #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = load_i ? data_i : {1'b0, data_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bit_o = data_q[0];

endmodule

// File: rtl/serv_rf_ram_bridge.sv
// Bridge between the bit-serial register-file request interface and a
// WIDTH-bit synchronous RAM. One request runs one 32-bit pass with two
// serial read ports and two serial write ports.
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_rreq / i_wreq          : start a read pass / a write-only pass
//   o_ready                  : one-cycle pulse, serial data starts next cycle
//   i_rreg0/1, o_rdata0/1    : read port indices and serial read data
//   i_wreg0/1, i_wen0/1,
//   i_wdata0/1               : write port indices, enables, serial data
//   o_raddr/o_ren/i_rdata    : RAM read side (data one cycle after o_ren)
//   o_waddr/o_wdata/o_wen    : RAM write side
//   o_dbg_state              : current FSM state
//
// Handshake: i_rreq/i_wreq are start strobes sampled only in IDLE; anything
// asserted while a pass is running is dropped. There is no backpressure:
// o_ready pulses exactly once per accepted request, RF_LAT cycles after
// acceptance, and the serial data follows on the next cycle.
module serv_rf_ram_bridge
    import serv_rf_ram_bridge_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CSR_REGS = 4,
    localparam int DEPTH    = PASS_LEN * (CSR_BASE + CSR_REGS) / WIDTH,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rreq,
    input  logic             i_wreq,
    output logic             o_ready,
    input  logic [5:0]       i_rreg0,
    input  logic [5:0]       i_rreg1,
    output logic             o_rdata0,
    output logic             o_rdata1,
    input  logic [5:0]       i_wreg0,
    input  logic [5:0]       i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic             i_wdata0,
    input  logic             i_wdata1,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen,
    output logic [1:0]       o_dbg_state
);

    localparam int LW = $clog2(WIDTH);

    // RAM address = {register index, bit position >> LW}
    function automatic logic [AW-1:0] make_addr(input logic [5:0] r, input logic [4:0] b);
        return AW'({r, b} >> LW);
    endfunction

    rf_state_e            state_q, state_d;
    logic [CNT_W-1:0]     pcnt_q, pcnt_d;
    logic                 is_read_q, is_read_d;
    logic [REG_IDX_W-1:0] rreg0_q, rreg0_d, rreg1_q, rreg1_d;
    logic [REG_IDX_W-1:0] wreg0_q, wreg0_d, wreg1_q, wreg1_d;
    logic                 rtrig0_q, rtrig0_d, rtrig1_q, rtrig1_d;
    logic [WIDTH-1:0]     wsh0_q, wsh0_d, wsh1_q, wsh1_d, hold1_q, hold1_d;
    logic                 wtrig0_q, wtrig0_d, wtrig1a_q, wtrig1a_d, wtrig1_q, wtrig1_d;

    logic                 accept, streaming, ren0, ren1, wlast;
    logic [CNT_W-1:0]     wcnt;
    logic [4:0]           wbit;
    logic                 sh0_bit, sh1_bit;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            is_read_q <= 1'b0;
            rreg0_q   <= '0;
            rreg1_q   <= '0;
            wreg0_q   <= '0;
            wreg1_q   <= '0;
            rtrig0_q  <= 1'b0;
            rtrig1_q  <= 1'b0;
            wsh0_q    <= '0;
            wsh1_q    <= '0;
            hold1_q   <= '0;
            wtrig0_q  <= 1'b0;
            wtrig1a_q <= 1'b0;
            wtrig1_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            is_read_q <= is_read_d;
            rreg0_q   <= rreg0_d;
            rreg1_q   <= rreg1_d;
            wreg0_q   <= wreg0_d;
            wreg1_q   <= wreg1_d;
            rtrig0_q  <= rtrig0_d;
            rtrig1_q  <= rtrig1_d;
            wsh0_q    <= wsh0_d;
            wsh1_q    <= wsh1_d;
            hold1_q   <= hold1_d;
            wtrig0_q  <= wtrig0_d;
            wtrig1a_q <= wtrig1a_d;
            wtrig1_q  <= wtrig1_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_rreq || i_wreq)          state_d = ST_PASS;
            ST_PASS:  if (pcnt_q == PCNT_STREAM_END) state_d = ST_DRAIN;
            ST_DRAIN: if (pcnt_q == PCNT_DRAIN_END)  state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        accept    = (state_q == ST_IDLE) && (i_rreq || i_wreq);
        streaming = (state_q == ST_PASS) && (pcnt_q >= CNT_W'(RF_LAT));
        // Port 0 reads the word on the first cycle of each WIDTH slot, port 1
        // on the second, so the single read port is time-shared.
        ren0 = (state_q == ST_PASS) && is_read_q && (pcnt_q < CNT_W'(PASS_LEN))
               && (pcnt_q[LW-1:0] == '0);
        ren1 = (state_q == ST_PASS) && is_read_q && (pcnt_q < CNT_W'(PASS_LEN))
               && (pcnt_q[LW-1:0] == LW'(1));
        // wcnt is the serial bit number being sampled this cycle.
        wcnt  = pcnt_q - CNT_W'(RF_LAT);
        wlast = &wcnt[LW-1:0];
        // At a write cycle wcnt has moved past the word; step back one word.
        wbit  = 5'(wcnt - CNT_W'(WIDTH));

        pcnt_d    = (state_q == ST_IDLE) ? '0 : pcnt_q + CNT_W'(1);
        is_read_d = accept ? i_rreq  : is_read_q;
        rreg0_d   = accept ? i_rreg0 : rreg0_q;
        rreg1_d   = accept ? i_rreg1 : rreg1_q;
        wreg0_d   = accept ? i_wreg0 : wreg0_q;
        wreg1_d   = accept ? i_wreg1 : wreg1_q;
        rtrig0_d  = ren0;
        rtrig1_d  = ren1;

        wsh0_d    = streaming ? {i_wdata0, wsh0_q[WIDTH-1:1]} : wsh0_q;
        wsh1_d    = streaming ? {i_wdata1, wsh1_q[WIDTH-1:1]} : wsh1_q;
        // Port 1 is written one cycle after port 0, by which time its shift
        // register already holds the next word's first bit; park the word.
        hold1_d   = (streaming && wlast) ? {i_wdata1, wsh1_q[WIDTH-1:1]} : hold1_q;
        wtrig0_d  = streaming && wlast && i_wen0;
        wtrig1a_d = streaming && wlast && i_wen1;
        wtrig1_d  = wtrig1a_q;
    end

    // Port 1 data arrives in the same cycle as its first serial bit, so that
    // bit bypasses the shift register and only the upper bits are loaded.
    serv_rf_shreg #(.WIDTH(WIDTH)) u_shreg0 (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .load_i (rtrig0_q),
        .data_i (i_rdata),
        .bit_o  (sh0_bit)
    );

    serv_rf_shreg #(.WIDTH(WIDTH)) u_shreg1 (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .load_i (rtrig1_q),
        .data_i ({1'b0, i_rdata[WIDTH-1:1]}),
        .bit_o  (sh1_bit)
    );

    // ---------------- outputs ----------------
    always_comb begin
        o_ready     = (state_q == ST_PASS) && (pcnt_q == CNT_W'(RF_LAT - 1));
        o_ren       = ren0 || ren1;
        o_raddr     = ren1 ? make_addr(rreg1_q, pcnt_q[4:0]) : make_addr(rreg0_q, pcnt_q[4:0]);
        // x0 reads as zero and is never written.
        o_rdata0    = streaming && is_read_q && (|rreg0_q) && sh0_bit;
        o_rdata1    = streaming && is_read_q && (|rreg1_q) && (rtrig1_q ? i_rdata[0] : sh1_bit);
        o_wen       = (wtrig0_q && (|wreg0_q)) || (wtrig1_q && (|wreg1_q));
        o_waddr     = wtrig1_q ? make_addr(wreg1_q, wbit) : make_addr(wreg0_q, wbit);
        o_wdata     = wtrig1_q ? hold1_q : wsh0_q;
        o_dbg_state = state_q;
    end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
module tb_serv_rf_ram_bridge;

    localparam int W        = 2;
    localparam int CSR_REGS = 4;
    localparam int NREG     = 32 + CSR_REGS;
    localparam int DEPTH    = 32 * NREG / W;
    localparam int AW       = $clog2(DEPTH);
    localparam int WPR      = 32 / W;   // RAM words per register

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          i_rreq, i_wreq, o_ready;
    logic [5:0]    i_rreg0, i_rreg1, i_wreg0, i_wreg1;
    logic          o_rdata0, o_rdata1;
    logic          i_wen0, i_wen1, i_wdata0, i_wdata1;
    logic [AW-1:0] o_raddr, o_waddr;
    logic          o_ren, o_wen;
    logic [W-1:0]  i_rdata, o_wdata;
    logic [1:0]    o_dbg_state;

    serv_rf_ram_bridge #(.WIDTH(W), .CSR_REGS(CSR_REGS)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready),
        .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- RAM model (with preload port) ----------------
    logic [W-1:0]  mem [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (o_wen) mem[o_waddr] <= o_wdata;
        if (o_ren) i_rdata <= mem[o_raddr];
    end

    // ---------------- reference register file ----------------
    logic [31:0] gold [NREG];

    function automatic logic [31:0] ram_reg(input int r);
        logic [31:0] v;
        for (int b = 0; b < 32; b++) v[b] = mem[(r * 32 + b) / W][b % W];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int r = 0; r < NREG; r++)
            check_eq($sformatf("%s_x%0d", tag, r), ram_reg(r), gold[r]);
    endtask

    // ---------------- pass driver ----------------
    // rst_cyc != 0 : pull reset low in that cycle of the pass (and the next)
    // extra_cyc != 0 : raise a stray i_rreq in that cycle of the pass
    task automatic run_pass(input string tag, input bit rd, input bit wr,
                            input logic [5:0] r0, input logic [5:0] r1,
                            input logic [5:0] w0, input logic [5:0] w1,
                            input bit we0, input bit we1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int extra_cyc, input int rst_cyc);
        logic [31:0] exp0, exp1, got0, got1;
        int ready_cnt, ready_cyc, ren_cnt, wen_cnt, x0_wen, late_wen, stray, post_rst_wen;
        int exp_wen;
        exp0 = (r0 == 6'd0) ? 32'd0 : gold[r0];
        exp1 = (r1 == 6'd0) ? 32'd0 : gold[r1];
        got0 = '0; got1 = '0;
        ready_cnt = 0; ready_cyc = 0; ren_cnt = 0; wen_cnt = 0;
        x0_wen = 0; late_wen = 0; stray = 0; post_rst_wen = 0;

        @(negedge clk);
        i_rreq = rd; i_wreq = wr;
        i_rreg0 = r0; i_rreg1 = r1; i_wreg0 = w0; i_wreg1 = w1;
        i_wen0 = we0; i_wen1 = we1;
        @(posedge clk);                          // acceptance edge T
        for (int j = 1; j <= 44; j++) begin      // iteration j samples cycle T+j
            @(negedge clk);
            i_rreq = 1'b0; i_wreq = 1'b0;
            if (o_ready) begin ready_cnt++; ready_cyc = j; end
            if (o_ren) ren_cnt++;
            if (o_wen) begin
                wen_cnt++;
                if (j > 36) late_wen++;
                if (int'(o_waddr) < WPR) x0_wen++;
                if (rst_cyc != 0 && j > rst_cyc) post_rst_wen++;
            end
            if (j >= 3 && j <= 34) begin
                got0[j - 3] = o_rdata0;
                got1[j - 3] = o_rdata1;
            end else if (o_rdata0 || o_rdata1) begin
                stray++;
            end
            if (rst_cyc != 0 && j == rst_cyc + 1)
                check_eq({tag, "_rst_outs"}, {27'd0, o_ready, o_ren, o_wen, o_rdata0, o_rdata1}, 32'd0);
            // drive inputs for cycle T+j (sampled at its closing edge)
            i_wdata0 = (j >= 3 && j <= 34) ? d0[j - 3] : 1'($urandom_range(0, 1));
            i_wdata1 = (j >= 3 && j <= 34) ? d1[j - 3] : 1'($urandom_range(0, 1));
            if (j == extra_cyc) i_rreq = 1'b1;
            if (rst_cyc != 0) rst_n = !(j == rst_cyc || j == rst_cyc + 1);
        end
        rst_n = 1'b1;

        if (rst_cyc == 0) begin
            check_eq({tag, "_ready_cnt"}, ready_cnt, 1);
            check_eq({tag, "_ready_cyc"}, ready_cyc, 2);
            check_eq({tag, "_ren_cnt"}, ren_cnt, rd ? 2 * WPR : 0);
            if (rd) begin
                check_eq({tag, "_rd0"}, got0, exp0);
                check_eq({tag, "_rd1"}, got1, exp1);
            end
            check_eq({tag, "_stray_rdata"}, stray, 0);
            exp_wen = ((we0 && w0 != 0) ? WPR : 0) + ((we1 && w1 != 0) ? WPR : 0);
            check_eq({tag, "_wen_cnt"}, wen_cnt, exp_wen);
            check_eq({tag, "_late_wen"}, late_wen, 0);
            if (we0 && w0 != 0) gold[w0] = d0;
            if (we1 && w1 != 0) gold[w1] = d1;
        end else begin
            check_eq({tag, "_post_rst_wen"}, post_rst_wen, 0);
            // Word k of port 0 lands in cycle T+3+W*(k+1), port 1 one cycle later;
            // only writes up to the reset edge survive.
            for (int k = 0; k < WPR; k++)
                if (we0 && w0 != 0 && 3 + W * (k + 1) <= rst_cyc) gold[w0][k * W +: W] = d0[k * W +: W];
            for (int k = 0; k < WPR; k++)
                if (we1 && w1 != 0 && 4 + W * (k + 1) <= rst_cyc) gold[w1][k * W +: W] = d1[k * W +: W];
        end
        check_eq({tag, "_x0_wen"}, x0_wen, 0);
        check_ram(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]  ra, rb, wa, wb;
        logic [31:0] da, db;
        bit          rd, wr;
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        i_rreq = 0; i_wreq = 0; i_rreg0 = 0; i_rreg1 = 0; i_wreg0 = 0; i_wreg1 = 0;
        i_wen0 = 0; i_wen1 = 0; i_wdata0 = 0; i_wdata1 = 0;

        for (int r = 0; r < NREG; r++) gold[r] = $urandom;
        gold[0] = 32'hCAFE_F00D;
        gold[5] = 32'hDEAD_BEEF;
        gold[6] = 32'h1234_5678;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = AW'(a);
            pl_data = gold[a / WPR][(a % WPR) * W +: W];
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_eq("reset_outs", {27'd0, o_ready, o_ren, o_wen, o_rdata0, o_rdata1}, 32'd0);
        check_ram("preload");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed scenarios
        run_pass("t1_read",      1, 0, 5, 6, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("t2_write",     0, 1, 0, 0, 7, 0, 1, 0, 32'hA5A5_F00F, 32'h0, 0, 0);
        run_pass("t2_readback",  1, 0, 7, 7, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("t3_dual_wr",   1, 0, 1, 2, 3, 33, 1, 1, 32'h1, 32'hFFFF_FFFF, 0, 0);
        run_pass("t3_readback",  1, 0, 3, 33, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("t4_wr_x0",     0, 1, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_pass("t4_rd_x0",     1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("t5_reset",     1, 0, 9, 10, 11, 12, 1, 1, $urandom, $urandom, 0, 10);
        run_pass("t5_after",     1, 0, 11, 12, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("t6_stray_req", 1, 0, 4, 5, 0, 0, 0, 0, 32'h0, 32'h0, 20, 0);
        run_pass("t6_both_req",  1, 1, 6, 34, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        run_pass("wen_off",      0, 1, 0, 0, 13, 14, 0, 0, $urandom, $urandom, 0, 0);

        // randomized passes
        for (int i = 0; i < 24; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            ra = 6'($urandom_range(0, NREG - 1));
            rb = 6'($urandom_range(0, NREG - 1));
            wa = 6'($urandom_range(0, NREG - 1));
            wb = 6'($urandom_range(0, NREG - 1));
            da = $urandom;
            db = $urandom;
            run_pass($sformatf("rnd%0d", i), rd, wr, ra, rb, wa, wb,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, db, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
